// File: rtl/kpn_fifo_channel.sv
// Bounded token FIFO between two KPN processes: registered occupancy flags,
// registered pop data, and sticky overflow/underflow error indicators.
module kpn_fifo_channel #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_pop;
    logic                  w_push;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Accept decisions; a push into a full channel is allowed only alongside an accepted pop.
    assign w_pop  = rd && (r_count != {(ADDR_WIDTH+1){1'b0}});
    assign w_push = wr && (!r_full || w_pop);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
            2'b01:   w_count_next = r_count - {{ADDR_WIDTH{1'b0}}, 1'b1};
            default: w_count_next = r_count;
        endcase
    end

    // Token storage; not cleared on reset, stale slots are unreachable via the pointers.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    // Pointers, occupancy, flags and pop data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= {ADDR_WIDTH{1'b0}};
            r_rptr       <= {ADDR_WIDTH{1'b0}};
            r_count      <= {(ADDR_WIDTH+1){1'b0}};
            r_data_out   <= {DATA_WIDTH{1'b0}};
            r_data_valid <= 1'b0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr       <= r_rptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                r_data_out   <= r_mem[r_rptr];
                r_data_valid <= 1'b1;
            end else begin
                r_data_valid <= 1'b0;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_MAX);
            r_empty <= (w_count_next == {(ADDR_WIDTH+1){1'b0}});
            if (wr && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (rd && !w_pop) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign full       = r_full;
    assign empty      = r_empty;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed table-driven bench for kpn_fifo_channel (DEPTH=8, 16-bit tokens),
// plus a hand-written full-throughput streaming sequence across pointer wraps.
module tb_kpn_fifo_channel;

    logic        clk;
    logic        reset;
    logic        wr;
    logic        rd;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [15:0] e_dout;
        logic        e_valid;
        logic [3:0]  e_count;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t vq[$];

    kpn_fifo_channel #(
        .DATA_WIDTH(16),
        .DEPTH     (8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .data_in   (data_in),
        .rd        (rd),
        .data_out  (data_out),
        .data_valid(data_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic w, input logic d_rd,
                                input logic [15:0] din, input logic [15:0] dout,
                                input logic vld, input logic [3:0] cnt,
                                input logic ovf, input logic udf);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = d_rd; v.din = din;
        v.e_dout = dout; v.e_valid = vld; v.e_count = cnt;
        v.e_ovf = ovf; v.e_udf = udf;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset   = v.rst;
        wr      = v.wr;
        rd      = v.rd;
        data_in = v.din;
        @(posedge clk);
        #1;
        chk("data_out",   idx, data_out, v.e_dout);
        chk("data_valid", idx, {15'd0, data_valid}, {15'd0, v.e_valid});
        chk("count",      idx, {12'd0, count}, {12'd0, v.e_count});
        chk("full",       idx, {15'd0, full}, {15'd0, (v.e_count == 4'd8)});
        chk("empty",      idx, {15'd0, empty}, {15'd0, (v.e_count == 4'd0)});
        chk("overflow",   idx, {15'd0, overflow}, {15'd0, v.e_ovf});
        chk("underflow",  idx, {15'd0, underflow}, {15'd0, v.e_udf});
    endtask

    initial begin
        vec_t sv;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        wr       = 1'b0;
        rd       = 1'b0;
        data_in  = 16'h0000;

        // reset, then idle
        add(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
        // push 1..8 then pop 1..8 in order
        for (int i = 1; i <= 8; i++)
            add(1'b0, 1'b1, 1'b0, 16'(i), 16'h0000, 1'b0, 4'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++)
            add(1'b0, 1'b0, 1'b1, 16'h0000, 16'(i), 1'b1, 4'(8 - i), 1'b0, 1'b0);
        // fill again, rejected push of DEAD, then drain
        for (int i = 1; i <= 8; i++)
            add(1'b0, 1'b1, 1'b0, 16'(i), 16'h0008, 1'b0, 4'(i), 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 16'hDEAD, 16'h0008, 1'b0, 4'd8, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++)
            add(1'b0, 1'b0, 1'b1, 16'h0000, 16'(i), 1'b1, 4'(8 - i), 1'b1, 1'b0);
        // pop on empty with simultaneous push of 1234
        add(1'b0, 1'b1, 1'b1, 16'h1234, 16'h0008, 1'b0, 4'd1, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, 1'b1, 4'd0, 1'b1, 1'b1);
        // push 3, pop 1, reset with wr/rd high, then push/pop AA
        add(1'b0, 1'b1, 1'b0, 16'h0011, 16'h1234, 1'b0, 4'd1, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 16'h0022, 16'h1234, 1'b0, 4'd2, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 16'h0033, 16'h1234, 1'b0, 4'd3, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0011, 1'b1, 4'd2, 1'b1, 1'b1);
        add(1'b1, 1'b1, 1'b1, 16'h0044, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 16'h00AA, 16'h0000, 1'b0, 4'd1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h00AA, 1'b1, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++)
            apply(vq[i], i);

        // Full-rate streaming: fill with 0x100.., then 20 cycles of wr+rd, then drain.
        sv.rst = 1'b0; sv.e_ovf = 1'b0; sv.e_udf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sv.wr = 1'b1; sv.rd = 1'b0; sv.din = 16'h0100 + 16'(i);
            sv.e_dout = 16'h00AA; sv.e_valid = 1'b0; sv.e_count = 4'(i + 1);
            apply(sv, 100 + i);
        end
        for (int i = 0; i < 20; i++) begin
            sv.wr = 1'b1; sv.rd = 1'b1; sv.din = 16'h0108 + 16'(i);
            sv.e_dout = 16'h0100 + 16'(i); sv.e_valid = 1'b1; sv.e_count = 4'd8;
            apply(sv, 200 + i);
        end
        for (int i = 0; i < 8; i++) begin
            sv.wr = 1'b0; sv.rd = 1'b1; sv.din = 16'h0000;
            sv.e_dout = 16'h0114 + 16'(i); sv.e_valid = 1'b1; sv.e_count = 4'(7 - i);
            apply(sv, 300 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kpn_fifo_channel.md
# kpn_fifo_channel

Bounded FIFO channel for the KPN process graph: buffers 16-bit tokens between a producer process and a consumer process such as the adder module. Each adder operand input is fed by one instance. The producer pushes with `wr` and the consumer pops with `rd`. The block supplies `full`/`empty` for blocking semantics and flags overflow and underflow.

## Interface
- `DATA_WIDTH`, 16, token width in bits
- `DEPTH`, 8, number of storage slots; must be a power of two, minimum 2
- `ADDR_WIDTH`, 3, log2(`DEPTH`)

- `clk`  input  1  sole clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `wr`  input  1  producer push request, sampled at rising edge
- `data_in`  input  `DATA_WIDTH`  token to push, sampled with `wr`
- `rd`  input  1  consumer pop request, sampled at rising edge
- `data_out`  output  `DATA_WIDTH`  last popped token (registered)
- `data_valid`  output  1  one-cycle pulse: `data_out` was updated by the most recent edge
- `full`  output  1  count == `DEPTH`
- `empty`  output  1  count == 0
- `count`  output  `ADDR_WIDTH`+1  tokens currently stored, 0..`DEPTH`
- `overflow`  output  1  sticky: a push was attempted while full and not accepted
- `underflow`  output  1  sticky: a pop was attempted while empty

## Operation
- Storage: `DEPTH` x `DATA_WIDTH` register array. Write pointer and read pointer are `ADDR_WIDTH` bits, wrap modulo `DEPTH`. Occupancy is held in the `count` register.
- Push accepted when `wr`=1 and either (count < `DEPTH`) or (full with a same-edge accepted pop).
  - On acceptance: mem[wptr] <= `data_in`, and wptr increments with wrap.
- Pop accepted when `rd`=1 and count > 0.
  - On acceptance: `data_out` <= mem[rptr], `data_valid` <= 1, and rptr increments with wrap.
  - Otherwise `data_valid` <= 0 and `data_out` holds its value.
- There is no write-to-read bypass. A token pushed at edge k can be popped no earlier than edge k+1.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Rejected push (full, no accepted pop): storage and wptr unchanged, `overflow` <= 1.
- Rejected pop (empty): `underflow` <= 1. This applies even if a push is accepted on the same edge.
- `overflow` and `underflow` stay set until `reset`.
- `full`, `empty`, `count` are registered and reflect state after the latest edge.
- Reset (`reset`=1 at an edge, overrides all other inputs):
  - wptr = rptr = 0, count = 0, `data_out` = 0, `data_valid` = 0, `overflow` = `underflow` = 0.
  - Hence `empty` = 1 and `full` = 0.
  - Memory contents are not cleared; they become unreachable.
- Arithmetic: `count` is `ADDR_WIDTH`+1 bits and never exceeds `DEPTH` or goes below 0. Pointer increments are unsigned, modulo `DEPTH`.

## Timing
- Push-to-visible latency: token written at edge k; `empty` deasserts after edge k; earliest pop is at edge k+1.
- Pop latency: `rd` sampled at edge k; `data_out`/`data_valid` valid after edge k, for the whole following cycle.
- Throughput: one push and one pop per cycle are sustained. When full, simultaneous `wr`+`rd` keeps `full`=1 and `count`=`DEPTH`.
- Empty boundary: `wr`+`rd` together at count 0 → push accepted, pop rejected, `underflow` set, `count`=1 after the edge.
- Full boundary: `wr` alone at count `DEPTH` → rejected, `overflow` set.
- Wrap-around: after `DEPTH` pushes, wptr returns to 0. Ordering is preserved across any number of wraps.
- Reset mid-stream: at the reset edge, all pending requests are ignored. The first push after deassertion lands in slot 0.
- The producer must gate `wr` on `full` and the consumer must gate `rd` on `empty`, both sampled in the same cycle. The flags are registered, so no combinational path runs from `wr`/`rd` to any output.

## Test plan
- Reset then idle → `empty`=1, `full`=0, `count`=0, `data_out`=0, `data_valid`=0, `overflow`=`underflow`=0.
- Push 0x0001..0x0008 (DEPTH=8), then 8 pops → `full`=1 after the 8th push. Pops return 0x0001..0x0008 in order, each with a `data_valid` pulse. `empty`=1 at the end, with no flags set.
- Fill to full, then push 0xDEAD alone → `overflow`=1 and `count`=8. The next pop returns 0x0001, and 0xDEAD never appears.
- Pop while empty with `wr`=1 and `data_in`=0x1234 on the same edge → `underflow`=1, `data_valid`=0, `count`=1. The next pop returns 0x1234.
- Hold full and assert `wr`+`rd` for 20 cycles with an incrementing token → `count` stays 8 and `full` stays 1. The popped stream is exactly the pushed stream delayed by 8 tokens across pointer wraps.
- Push 3 tokens, pop 1, assert `reset` for one edge with `wr`=`rd`=1 → all outputs return to reset values. Then push 0x00AA and pop → `data_out`=0x00AA.
